multi_lab_access_ctrl: RTL and testbench
========================================

// Module: multi_lab_access_ctrl
// PURPOSE
//   Parametrised smart-card door controller for NUM_LABS labs sharing one card reader.
//   - Per-lab occupancy counter with full/empty flags.
//   - Code-parity restriction once occupancy reaches a threshold.
//   - One-cycle door-unlock pulse on each granted request.
//   - Brute-force lockout after repeated denied entries.
//   Sits between the card-reader front end and the per-lab door actuators / status displays.
// PARAMETERS
//   NUM_LABS        4   number of labs served
//   LAB_SEL_W       2   width of lab select; 2**LAB_SEL_W >= NUM_LABS
//   CODE_W          5   smart-card code width
//   CAPACITY        30  max students per lab
//   CNT_W           6   occupancy counter width; 2**CNT_W > CAPACITY
//   RESTRICT_THRESH 15  occupancy at/above which the parity restriction applies
//   DENY_LIMIT      3   consecutive denied entries that trigger lockout
//   LOCK_CYCLES     8   lockout duration in CLK cycles
// PORTS
//   CLK         in   1                clock, all state updates on rising edge
//   RST         in   1                synchronous reset, active-high
//   smartCode   in   CODE_W           card code presented this cycle
//   lab         in   LAB_SEL_W        target lab index
//   mode        in   2                00 idle, 01 entry, 10 exit, 11 admin clear
//   numOfStu    out  NUM_LABS*CNT_W   occupancy; lab i at [i*CNT_W +: CNT_W]
//   restrictionWarn out NUM_LABS      1 = last entry to lab i refused by parity rule
//   isFull      out  NUM_LABS         1 = count == CAPACITY
//   isEmpty     out  NUM_LABS         1 = count == 0
//   unlock      out  NUM_LABS         1-cycle pulse: door i opened
//   lockedOut   out  NUM_LABS         1 = lab i in LOCKED state
// BEHAVIOUR
//   - Reset (RST=1 at a rising edge) overrides all requests, and also takes effect mid-lockout:
//     - counts = 0, isEmpty = all 1s, isFull = 0, restrictionWarn = 0, unlock = 0, lockedOut = 0;
//     - deny counters and lock timers = 0, every lab in state OPEN.
//   - Request handling:
//     - Inputs are sampled on the rising edge; outputs are registered and valid after that edge (latency 1).
//     - isFull and isEmpty are decoded from the registered counts.
//     - Only lab[lab] is affected. If lab >= NUM_LABS, or mode = 00, all state holds.
//     - unlock and restrictionWarn of every lab not served this cycle drop to 0.
//   - Entry (mode 01), selected lab in OPEN:
//     - count == CAPACITY -> deny; warn = 0; deny counter +1.
//     - count >= RESTRICT_THRESH and smartCode has even parity -> deny; warn = 1; deny counter +1.
//     - otherwise -> count +1; unlock = 1; warn = 0; deny counter = 0.
//     - Parity: the XOR of all smartCode bits must be 1.
//   - Entry (mode 01), selected lab in LOCKED:
//     - deny; unlock = 0; warn = 0; deny counter unchanged.
//   - Exit (mode 10), allowed in OPEN and LOCKED alike (safety egress):
//     - count > 0 -> count -1, unlock = 1.
//     - count == 0 -> no change, unlock = 0, no underflow.
//   - Admin clear (mode 11):
//     - selected lab: count = 0, deny counter = 0, timer = 0, state = OPEN; unlock = 0, warn = 0.
//   - Per-lab FSM:
//     - OPEN -> LOCKED when a denial makes the deny counter reach DENY_LIMIT.
//       On that edge: lock timer loads LOCK_CYCLES and the deny counter clears.
//     - LOCKED: timer decrements every cycle, independent of requests.
//       LOCKED -> OPEN on the edge where the timer goes 1 -> 0.
//     - lockedOut = 1 for exactly LOCK_CYCLES cycles.
//     - A lab in LOCKED is served as OPEN on the cycle after it unlocks.
//   - Counters saturate; they never wrap. Labs are fully independent except for the shared inputs.
// TESTING
//   1. RST=1 one edge, then idle -> all numOfStu = 0, isEmpty = 4'b1111, all other outputs 0.
//   2. Entry to lab 2 with code 5'b00001 x15 -> count 15, unlock pulses each cycle;
//      then code 5'b00011 -> count stays 15, restrictionWarn[2] = 1;
//      then 5'b00111 -> count 16, warn = 0.
//   3. Fill lab 0 to 30 with odd-parity codes -> isFull[0] = 1;
//      a further entry is denied with unlock = 0, warn = 0;
//      one exit -> count 29, isFull[0] = 0.
//   4. Three consecutive even-parity entries to lab 1 at count 20 -> lockedOut[1] = 1 for 8 cycles.
//      - During the lockout: odd-parity entries are denied and an exit decrements to 19 with unlock pulse.
//      - The cycle after the lockout: an odd-parity entry is granted.
//   5. Exit from empty lab 3 -> count stays 0, unlock = 0.
//      lab = 3 with NUM_LABS = 3 -> no state change anywhere.
//   6. RST asserted mid-lockout with count 12 -> next cycle count 0 and lockedOut 0;
//      mode 11 on a locked lab clears its count and lock in one edge.

Source files
------------

// File: rtl/multi_lab_access_ctrl.sv
// Smart-card door controller for several labs sharing one card reader.
// Each lab keeps an occupancy count, a consecutive-denial counter and a
// lockout timer. Requests are sampled on the rising clock edge and every
// output is driven from a register, so results appear one cycle later.
module multi_lab_access_ctrl #(
    parameter int NUM_LABS        = 4,
    parameter int LAB_SEL_W       = 2,
    parameter int CODE_W          = 5,
    parameter int CAPACITY        = 30,
    parameter int CNT_W           = 6,
    parameter int RESTRICT_THRESH = 15,
    parameter int DENY_LIMIT      = 3,
    parameter int LOCK_CYCLES     = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CODE_W-1:0]         smartCode,
    input  logic [LAB_SEL_W-1:0]      lab,
    input  logic [1:0]                mode,
    output logic [NUM_LABS*CNT_W-1:0] numOfStu,
    output logic [NUM_LABS-1:0]       restrictionWarn,
    output logic [NUM_LABS-1:0]       isFull,
    output logic [NUM_LABS-1:0]       isEmpty,
    output logic [NUM_LABS-1:0]       unlock,
    output logic [NUM_LABS-1:0]       lockedOut
);

    localparam int DENY_W = $clog2(DENY_LIMIT + 1);
    localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] MODE_ENTRY = 2'b01;
    localparam logic [1:0] MODE_EXIT  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam logic [CNT_W-1:0]  L_CAP      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0]  L_THRESH   = CNT_W'(RESTRICT_THRESH);
    localparam logic [DENY_W-1:0] L_DENY_TOP = DENY_W'(DENY_LIMIT - 1);
    localparam logic [TMR_W-1:0]  L_LOCK     = TMR_W'(LOCK_CYCLES);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lab_state_t;

    // A card is acceptable under the restriction only with odd parity.
    function automatic logic code_parity_ok(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

    lab_state_t        r_state   [NUM_LABS];
    logic [CNT_W-1:0]  r_cnt     [NUM_LABS];
    logic [DENY_W-1:0] r_deny    [NUM_LABS];
    logic [TMR_W-1:0]  r_timer   [NUM_LABS];
    logic [NUM_LABS-1:0] r_unlock;
    logic [NUM_LABS-1:0] r_warn;
    logic [NUM_LABS-1:0] r_full;
    logic [NUM_LABS-1:0] r_empty;

    lab_state_t        w_state_nxt [NUM_LABS];
    logic [CNT_W-1:0]  w_cnt_nxt   [NUM_LABS];
    logic [DENY_W-1:0] w_deny_nxt  [NUM_LABS];
    logic [TMR_W-1:0]  w_timer_nxt [NUM_LABS];
    logic [NUM_LABS-1:0] w_unlock_nxt;
    logic [NUM_LABS-1:0] w_warn_nxt;
    logic [NUM_LABS-1:0] w_denied;
    logic                w_lab_valid;
    logic                w_parity_ok;

    assign w_lab_valid = (int'(lab) < NUM_LABS);
    assign w_parity_ok = code_parity_ok(smartCode);

    // Next-state logic for every lab: lockout timer, then the request for the selected lab.
    always_comb begin
        for (int i = 0; i < NUM_LABS; i++) begin
            w_state_nxt[i]  = r_state[i];
            w_cnt_nxt[i]    = r_cnt[i];
            w_deny_nxt[i]   = r_deny[i];
            w_timer_nxt[i]  = r_timer[i];
            w_unlock_nxt[i] = 1'b0;
            w_warn_nxt[i]   = 1'b0;
            w_denied[i]     = 1'b0;

            // The lockout timer runs regardless of what is being requested.
            if (r_state[i] == ST_LOCKED) begin
                if (r_timer[i] <= TMR_W'(1)) begin
                    w_state_nxt[i] = ST_OPEN;
                    w_timer_nxt[i] = '0;
                end else begin
                    w_timer_nxt[i] = r_timer[i] - TMR_W'(1);
                end
            end else begin
                w_timer_nxt[i] = r_timer[i];
            end

            if (w_lab_valid && (int'(lab) == i)) begin
                case (mode)
                    MODE_ENTRY: begin
                        if (r_state[i] == ST_OPEN) begin
                            if (r_cnt[i] == L_CAP) begin
                                w_denied[i] = 1'b1;
                            end else if ((r_cnt[i] >= L_THRESH) && !w_parity_ok) begin
                                w_denied[i]   = 1'b1;
                                w_warn_nxt[i] = 1'b1;
                            end else begin
                                w_cnt_nxt[i]    = r_cnt[i] + CNT_W'(1);
                                w_unlock_nxt[i] = 1'b1;
                                w_deny_nxt[i]   = '0;
                            end
                        end else begin
                            // Locked labs refuse entry without touching the deny count.
                            w_denied[i] = 1'b0;
                        end
                    end
                    MODE_EXIT: begin
                        // Egress is always allowed, even while locked.
                        if (r_cnt[i] != '0) begin
                            w_cnt_nxt[i]    = r_cnt[i] - CNT_W'(1);
                            w_unlock_nxt[i] = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i];
                        end
                    end
                    MODE_CLEAR: begin
                        w_cnt_nxt[i]   = '0;
                        w_deny_nxt[i]  = '0;
                        w_timer_nxt[i] = '0;
                        w_state_nxt[i] = ST_OPEN;
                    end
                    default: begin
                        w_cnt_nxt[i] = r_cnt[i];
                    end
                endcase
            end

            // A denial either bumps the deny count or, on reaching the limit, locks the lab.
            if (w_denied[i]) begin
                if (r_deny[i] >= L_DENY_TOP) begin
                    w_state_nxt[i] = ST_LOCKED;
                    w_timer_nxt[i] = L_LOCK;
                    w_deny_nxt[i]  = '0;
                end else begin
                    w_deny_nxt[i] = r_deny[i] + DENY_W'(1);
                end
            end else begin
                w_denied[i] = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_LABS; i++) begin
                r_state[i] <= ST_OPEN;
                r_cnt[i]   <= '0;
                r_deny[i]  <= '0;
                r_timer[i] <= '0;
            end
            r_unlock <= '0;
            r_warn   <= '0;
            r_full   <= '0;
            r_empty  <= '1;
        end else begin
            for (int i = 0; i < NUM_LABS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_deny[i]  <= w_deny_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
                r_full[i]  <= (w_cnt_nxt[i] == L_CAP);
                r_empty[i] <= (w_cnt_nxt[i] == '0);
            end
            r_unlock <= w_unlock_nxt;
            r_warn   <= w_warn_nxt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LABS; g++) begin : g_out
            assign numOfStu[g*CNT_W +: CNT_W] = r_cnt[g];
            assign lockedOut[g]               = (r_state[g] == ST_LOCKED);
        end
    endgenerate

    assign restrictionWarn = r_warn;
    assign isFull          = r_full;
    assign isEmpty         = r_empty;
    assign unlock          = r_unlock;

endmodule

// File: tb/tb_multi_lab_access_ctrl.sv
// Directed bench for multi_lab_access_ctrl: a behavioural lab model pushes
// expected outputs into a queue as each request is driven; they are popped
// and compared one cycle later. A second instance with three labs covers
// an out-of-range lab index.
module tb_multi_lab_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [4:0]  smartCode = 5'd0;
    logic [1:0]  lab = 2'd0;
    logic [1:0]  mode = 2'b00;
    logic [23:0] numOfStu;
    logic [3:0]  restrictionWarn, isFull, isEmpty, unlock, lockedOut;

    logic        rst3 = 1'b0;
    logic [4:0]  code3 = 5'd0;
    logic [1:0]  lab3 = 2'd0;
    logic [1:0]  mode3 = 2'b00;
    logic [17:0] num3;
    logic [2:0]  warn3, full3, empty3, unl3, lock3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] cnt;
        logic [3:0]  unl;
        logic [3:0]  warn;
        logic [3:0]  full;
        logic [3:0]  empty;
        logic [3:0]  lock;
    } exp_t;
    exp_t exp_q[$];

    int       m_cnt [4];
    int       m_deny[4];
    int       m_tmr [4];
    bit [3:0] m_lock;
    bit [3:0] m_unl;
    bit [3:0] m_warn;

    multi_lab_access_ctrl u_dut (
        .CLK(CLK), .RST(RST), .smartCode(smartCode), .lab(lab), .mode(mode),
        .numOfStu(numOfStu), .restrictionWarn(restrictionWarn), .isFull(isFull),
        .isEmpty(isEmpty), .unlock(unlock), .lockedOut(lockedOut)
    );

    multi_lab_access_ctrl #(.NUM_LABS(3)) u_dut3 (
        .CLK(CLK), .RST(rst3), .smartCode(code3), .lab(lab3), .mode(mode3),
        .numOfStu(num3), .restrictionWarn(warn3), .isFull(full3),
        .isEmpty(empty3), .unlock(unl3), .lockedOut(lock3)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_deny[i] = 0; m_tmr[i] = 0;
        end
        m_lock = '0; m_unl = '0; m_warn = '0;
    endtask

    task automatic model_deny(input int l);
        m_deny[l]++;
        if (m_deny[l] >= 3) begin
            m_lock[l] = 1'b1;
            m_tmr[l]  = 8;
            m_deny[l] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] md, input logic [1:0] lb, input logic [4:0] code);
        int l;
        bit was_locked;
        l = int'(lb);
        was_locked = m_lock[l];
        m_unl = '0;
        m_warn = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_lock[i]) begin
                m_tmr[i]--;
                if (m_tmr[i] == 0) m_lock[i] = 1'b0;
            end
        end
        case (md)
            2'b01: begin
                if (!was_locked) begin
                    if (m_cnt[l] == 30) begin
                        model_deny(l);
                    end else if (m_cnt[l] >= 15 && (^code) == 1'b0) begin
                        m_warn[l] = 1'b1;
                        model_deny(l);
                    end else begin
                        m_cnt[l]++;
                        m_unl[l] = 1'b1;
                        m_deny[l] = 0;
                    end
                end
            end
            2'b10: begin
                if (m_cnt[l] > 0) begin
                    m_cnt[l]--;
                    m_unl[l] = 1'b1;
                end
            end
            2'b11: begin
                m_cnt[l] = 0; m_deny[l] = 0; m_tmr[l] = 0; m_lock[l] = 1'b0;
            end
            default: ;
        endcase
    endtask

    function automatic exp_t snap();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.cnt[i*6 +: 6] = 6'(m_cnt[i]);
            e.full[i]  = (m_cnt[i] == 30);
            e.empty[i] = (m_cnt[i] == 0);
        end
        e.unl  = m_unl;
        e.warn = m_warn;
        e.lock = m_lock;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("numOfStu", 32'(numOfStu), 32'(e.cnt));
            chk("unlock", 32'(unlock), 32'(e.unl));
            chk("restrictionWarn", 32'(restrictionWarn), 32'(e.warn));
            chk("isFull", 32'(isFull), 32'(e.full));
            chk("isEmpty", 32'(isEmpty), 32'(e.empty));
            chk("lockedOut", 32'(lockedOut), 32'(e.lock));
        end
    endtask

    task automatic step(input logic [1:0] md, input logic [1:0] lb, input logic [4:0] code);
        mode = md; lab = lb; smartCode = code; RST = 1'b0;
        model_step(md, lb, code);
        exp_q.push_back(snap());
        @(posedge CLK);
        #1;
        check_out();
    endtask

    task automatic step_rst();
        RST = 1'b1; mode = 2'b01; lab = 2'd1; smartCode = 5'b00001;
        model_reset();
        exp_q.push_back(snap());
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_out();
    endtask

    task automatic step3(input logic r, input logic [1:0] md, input logic [1:0] lb);
        rst3 = r; mode3 = md; lab3 = lb; code3 = 5'b00001;
        @(posedge CLK);
        #1;
        rst3 = 1'b0;
    endtask

    int locked_cycles;

    initial begin
        #1;
        // 1: reset and idle
        step_rst();
        step(2'b00, 2'd0, 5'd0);
        step(2'b00, 2'd3, 5'd0);
        chk("reset_empty", 32'(isEmpty), 32'hF);

        // 2: parity restriction on lab 2
        for (int k = 0; k < 15; k++) step(2'b01, 2'd2, 5'b00001);
        chk("lab2_cnt15", 32'(numOfStu[12 +: 6]), 32'd15);
        step(2'b01, 2'd2, 5'b00011);
        chk("lab2_warn", 32'(restrictionWarn[2]), 32'd1);
        chk("lab2_hold15", 32'(numOfStu[12 +: 6]), 32'd15);
        step(2'b01, 2'd2, 5'b00111);
        chk("lab2_cnt16", 32'(numOfStu[12 +: 6]), 32'd16);

        // 3: fill lab 0 to capacity
        for (int k = 0; k < 30; k++) step(2'b01, 2'd0, 5'b00001);
        chk("lab0_full", 32'(isFull[0]), 32'd1);
        step(2'b01, 2'd0, 5'b00001);
        chk("lab0_full_deny_unlock", 32'(unlock[0]), 32'd0);
        step(2'b10, 2'd0, 5'b00000);
        chk("lab0_cnt29", 32'(numOfStu[0 +: 6]), 32'd29);

        // 4: brute-force lockout on lab 1
        for (int k = 0; k < 20; k++) step(2'b01, 2'd1, 5'b00001);
        step(2'b01, 2'd1, 5'b00011);
        step(2'b01, 2'd1, 5'b00011);
        step(2'b01, 2'd1, 5'b00011);
        locked_cycles = int'(lockedOut[1]);
        step(2'b01, 2'd1, 5'b00001);
        locked_cycles += int'(lockedOut[1]);
        step(2'b01, 2'd1, 5'b00111);
        locked_cycles += int'(lockedOut[1]);
        step(2'b10, 2'd1, 5'b00000);
        locked_cycles += int'(lockedOut[1]);
        chk("lab1_exit_locked", 32'(numOfStu[6 +: 6]), 32'd19);
        for (int k = 0; k < 6; k++) begin
            step(2'b00, 2'd1, 5'b00000);
            locked_cycles += int'(lockedOut[1]);
        end
        chk("lab1_lock_len", 32'(locked_cycles), 32'd8);
        step(2'b01, 2'd1, 5'b00001);
        chk("lab1_grant_after", 32'(numOfStu[6 +: 6]), 32'd20);

        // 5: exit from empty lab 3, and out-of-range lab on the 3-lab instance
        step(2'b10, 2'd3, 5'b00000);
        chk("lab3_no_underflow", 32'(unlock[3]), 32'd0);
        step3(1'b1, 2'b00, 2'd0);
        step3(1'b0, 2'b01, 2'd0);
        chk("dut3_lab0_unlock", 32'(unl3), 32'd1);
        step3(1'b0, 2'b01, 2'd3);
        chk("dut3_oor_entry_cnt", 32'(num3), 32'd1);
        chk("dut3_oor_entry_unl", 32'(unl3), 32'd0);
        step3(1'b0, 2'b11, 2'd3);
        chk("dut3_oor_clear_cnt", 32'(num3), 32'd1);

        // 6: reset during lockout, then admin clear of a locked lab
        for (int k = 0; k < 15; k++) step(2'b01, 2'd3, 5'b00001);
        for (int k = 0; k < 3; k++) step(2'b01, 2'd3, 5'b00000);
        for (int k = 0; k < 3; k++) step(2'b10, 2'd3, 5'b00000);
        chk("lab3_locked_cnt12", 32'(numOfStu[18 +: 6]), 32'd12);
        step_rst();
        chk("rst_mid_lock", 32'(lockedOut), 32'd0);
        for (int k = 0; k < 16; k++) step(2'b01, 2'd1, 5'b00001);
        for (int k = 0; k < 3; k++) step(2'b01, 2'd1, 5'b01100);
        chk("lab1_relocked", 32'(lockedOut[1]), 32'd1);
        step(2'b11, 2'd1, 5'b00000);
        chk("clear_cnt", 32'(numOfStu[6 +: 6]), 32'd0);
        step(2'b01, 2'd1, 5'b00000);
        step(2'b00, 2'd0, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
